// File: rtl/theremin_freq_counter.sv
// ---------------------------------------------------------------------------
// theremin_freq_counter
//
// Gated frequency counter for the theremin pitch oscillator. Rising edges of
// the asynchronous osc_in square wave are counted over a fixed window of
// GATE_CYCLES clocks. Each window's count is latched as a result for the CPU,
// which reads it over an Avalon-MM slave port. An optional interrupt signals
// that a new result is available.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   osc_in         asynchronous oscillator input (phases >= 2 clk periods)
//   avs_address    register word address (0 RESULT, 1 STATUS, 2 CTRL, 3 GATE)
//   avs_read       read strobe; avs_readdata is valid one cycle later
//   avs_readdata   registered read data; holds its value between reads
//   avs_write      write strobe (only CTRL is writable)
//   avs_writedata  write data
//   irq            level interrupt: status.new & ctrl.irq_en, registered
//   meas_count     last latched result (conduit)
//   meas_valid     one-cycle pulse when meas_count updates
// ---------------------------------------------------------------------------
module theremin_freq_counter #(
    parameter int GATE_CYCLES = 500000,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             osc_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             irq,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid
);

    localparam int               GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Register addresses
    localparam logic [1:0] ADDR_RESULT = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_GATE   = 2'd3;

    // Synchronizer chain plus one extra stage for edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    // Measurement state
    logic [GW-1:0]    gate_q,    gate_d;
    logic [CNT_W-1:0] edge_q,    edge_d;
    logic             ovf_run_q, ovf_run_d;
    logic [CNT_W-1:0] result_q,  result_d;
    logic             valid_q,   valid_d;

    // Registers visible to the CPU
    logic             new_q,     new_d;
    logic             ovf_q,     ovf_d;
    logic [1:0]       ctrl_q,    ctrl_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic             irq_q,     irq_d;

    logic             enable;
    logic             terminal;
    logic             edge_at_max;
    logic             unused_wdata;

    // Only the two CTRL bits of the write bus carry information.
    assign unused_wdata = ^avs_writedata[31:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise        = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign enable      = ctrl_q[0];
    assign terminal    = enable && (gate_q == GATE_LAST);
    assign edge_at_max = (edge_q == CNT_MAX);

    always_comb begin
        gate_d    = gate_q;
        edge_d    = edge_q;
        ovf_run_d = ovf_run_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        new_d     = new_q;
        valid_d   = 1'b0;
        ctrl_d    = ctrl_q;
        rdata_d   = rdata_q;

        if (!enable) begin
            // Idle: counters held at zero so the first window after an
            // enable starts from a clean state.
            gate_d    = '0;
            edge_d    = '0;
            ovf_run_d = 1'b0;
        end else if (terminal) begin
            // A rise on the terminal cycle belongs to the window that ends
            // here; the next window starts from zero.
            gate_d    = '0;
            edge_d    = '0;
            ovf_run_d = 1'b0;
            result_d  = (rise && !edge_at_max) ? edge_q + 1'b1 : edge_q;
            ovf_d     = ovf_run_q | (rise & edge_at_max);
            valid_d   = 1'b1;
        end else begin
            gate_d = gate_q + 1'b1;
            if (rise) begin
                if (edge_at_max) begin
                    ovf_run_d = 1'b1;
                end else begin
                    edge_d = edge_q + 1'b1;
                end
            end
        end

        // Clearing read first so that a coincident capture wins.
        if (avs_read && (avs_address == ADDR_RESULT)) begin
            new_d = 1'b0;
        end
        if (terminal) begin
            new_d = 1'b1;
        end

        if (avs_write && (avs_address == ADDR_CTRL)) begin
            ctrl_d = avs_writedata[1:0];
        end

        // Read mux uses current register values, so a same-cycle CTRL write
        // or capture is not visible until the following read.
        if (avs_read) begin
            case (avs_address)
                ADDR_RESULT: rdata_d = 32'(result_q);
                ADDR_STATUS: rdata_d = {30'd0, ovf_q, new_q};
                ADDR_CTRL:   rdata_d = {30'd0, ctrl_q};
                ADDR_GATE:   rdata_d = 32'(GATE_CYCLES);
                default:     rdata_d = 32'd0;
            endcase
        end

        irq_d = new_d & ctrl_d[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_q    <= '0;
            edge_q    <= '0;
            ovf_run_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            new_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ctrl_q    <= 2'b00;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            gate_q    <= gate_d;
            edge_q    <= edge_d;
            ovf_run_q <= ovf_run_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            new_q     <= new_d;
            ovf_q     <= ovf_d;
            ctrl_q    <= ctrl_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign meas_count   = result_q;
    assign meas_valid   = valid_q;

endmodule
